// File: rtl/multi_timer.sv
// multi_timer: NUM_CH independent down-counter timer channels for the CPU bridge.
// Each channel has one-shot, auto-reload and PWM modes, a prescaler, a pending
// flag and an interrupt mask. Four word registers per channel:
// 0 CTRL, 1 PRESET, 2 COUNT (read-only), 3 CMP.
//
// Ports:
//   clk      system clock
//   reset    synchronous, active-high reset
//   Addr     word address (byte address bits [31:2])
//   WE       write enable for the addressed register
//   Din      write data
//   Dout     combinational read data of the addressed register
//   IRQ      OR over channels of (pending & mask)
//   irq_vec  per-channel pending & mask
//   pwm_out  registered per-channel PWM outputs
module multi_timer #(
  parameter int NUM_CH   = 2,
  parameter int WIDTH    = 32,
  parameter int PSC_BITS = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [29:0]       Addr,
  input  logic              WE,
  input  logic [31:0]       Din,
  output logic [31:0]       Dout,
  output logic              IRQ,
  output logic [NUM_CH-1:0] irq_vec,
  output logic [NUM_CH-1:0] pwm_out
);

  localparam int CH_BITS = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  typedef enum logic [1:0] {IDLE, LOAD, CNT, DONE} state_t;

  logic [CH_BITS-1:0]           chan;
  logic [1:0]                   reg_sel;
  logic [NUM_CH-1:0][31:0]      ch_rdata;
  logic                         addr_unused;

  // Addr is a word address, so byte bits [3:2] land on Addr[1:0].
  assign reg_sel     = Addr[1:0];
  assign chan        = Addr[CH_BITS+1:2];
  assign addr_unused = &{1'b0, Addr[29:CH_BITS+2], Din};

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    state_t              state_q, state_n;
    logic                en_q, en_n;
    logic [1:0]          mode_q, mode_n;
    logic                im_q;
    logic [PSC_BITS-1:0] psc_q, psc_cnt_q, psc_cnt_n;
    logic [WIDTH-1:0]    preset_q, count_q, count_n, cmp_q, cmp_n;
    logic                pend_q, pend_n;
    logic                pwm_p1, pwm_n;
    logic                sel, ctrl_wr, tick, expire;
    logic [31:0]         rdata;

    assign sel     = WE && (chan == CH_BITS'(c));
    assign ctrl_wr = sel && (reg_sel == 2'd0);
    assign tick    = (psc_cnt_q == psc_q);

    always_comb begin
      state_n   = state_q;
      count_n   = count_q;
      psc_cnt_n = psc_cnt_q;
      en_n      = en_q;
      expire    = 1'b0;
      case (state_q)
        IDLE: if (en_q) state_n = LOAD;
        LOAD: begin
          count_n   = preset_q;
          psc_cnt_n = '0;
          state_n   = CNT;
        end
        CNT: begin
          if (!en_q) begin
            state_n = IDLE;
          end else begin
            psc_cnt_n = tick ? '0 : psc_cnt_q + PSC_BITS'(1);
            if (tick) begin
              // COUNT<=1 also covers PRESET=0: expiry on the first tick.
              if (count_q > WIDTH'(1)) begin
                count_n = count_q - WIDTH'(1);
              end else begin
                count_n = '0;
                expire  = 1'b1;
                state_n = DONE;
              end
            end
          end
        end
        DONE: begin
          if (mode_q == 2'b01 || mode_q == 2'b10) begin
            state_n = en_q ? LOAD : IDLE;
          end else begin
            en_n    = 1'b0;
            state_n = IDLE;
          end
        end
        default: state_n = IDLE;
      endcase
      // A software CTRL write overrides the one-shot auto-disable.
      if (ctrl_wr) en_n = Din[0];
      mode_n = ctrl_wr ? Din[2:1] : mode_q;
      cmp_n  = (sel && reg_sel == 2'd3) ? Din[WIDTH-1:0] : cmp_q;
      // Expiry beats a simultaneous clear.
      pend_n = (pend_q && !(ctrl_wr && Din[31])) || expire;
      // Evaluated on next-state values so the registered output lines up
      // with the COUNT value visible in the same cycle.
      pwm_n  = (state_n == CNT) && (mode_n == 2'b10) && (count_n < cmp_n);
    end

    always_ff @(posedge clk) begin
      if (reset) begin
        state_q   <= IDLE;
        en_q      <= 1'b0;
        mode_q    <= 2'b00;
        im_q      <= 1'b0;
        psc_q     <= '0;
        psc_cnt_q <= '0;
        preset_q  <= '0;
        count_q   <= '0;
        cmp_q     <= '0;
        pend_q    <= 1'b0;
        pwm_p1    <= 1'b0;
      end else begin
        state_q   <= state_n;
        en_q      <= en_n;
        mode_q    <= mode_n;
        psc_cnt_q <= psc_cnt_n;
        count_q   <= count_n;
        cmp_q     <= cmp_n;
        pend_q    <= pend_n;
        pwm_p1    <= pwm_n;
        if (ctrl_wr) begin
          im_q  <= Din[3];
          psc_q <= Din[8 +: PSC_BITS];
        end
        if (sel && reg_sel == 2'd1) preset_q <= Din[WIDTH-1:0];
      end
    end

    always_comb begin
      rdata = '0;
      case (reg_sel)
        2'd0: begin
          rdata[0]            = en_q;
          rdata[2:1]          = mode_q;
          rdata[3]            = im_q;
          rdata[8 +: PSC_BITS] = psc_q;
          rdata[31]           = pend_q;
        end
        2'd1:    rdata[WIDTH-1:0] = preset_q;
        2'd2:    rdata[WIDTH-1:0] = count_q;
        default: rdata[WIDTH-1:0] = cmp_q;
      endcase
    end

    assign ch_rdata[c] = rdata;
    assign irq_vec[c]  = pend_q & im_q;
    assign pwm_out[c]  = pwm_p1;
  end

  // Unmapped channel indices fall through to zero.
  always_comb begin
    Dout = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (chan == CH_BITS'(c)) Dout = ch_rdata[c];
    end
  end

  assign IRQ = |irq_vec;

endmodule
